video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen_if.sv | 33 +++
 rtl/video_timing_gen.sv | 133 +++++++++++++
 tb/tb_video_timing_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Signal bundle between the video timing generator and its consumers
// (pixel fetch, CPU interrupt logic, serial scroll source).
interface video_timing_gen_if #(
  parameter int PIX_W = 9,
  parameter int ROW_W = 8
);
  logic                     phi2;
  logic                     not_phi2;
  logic                     hsync;
  logic                     vsync;
  logic                     visible;
  logic [PIX_W+ROW_W-1:0]   scan_addr;
  logic [9:0]               line_y;
  logic                     shift_clock;
  logic                     shift_data;
  logic                     irq_n;
  logic                     irq_ack;
  logic                     unhold;
  logic                     nmi_in;

  // Interrupt handshake: irq_n is a level held low by the generator until either
  // the vsync window ends or the consumer pulses irq_ack for one master_clock;
  // an ack in the same cycle as a new assertion wins and irq_n stays high.
  modport master (
    output phi2, not_phi2, hsync, vsync, visible, scan_addr, line_y, irq_n,
    input  shift_clock, shift_data, irq_ack, unhold, nmi_in
  );

  modport slave (
    input  phi2, not_phi2, hsync, vsync, visible, scan_addr, line_y, irq_n,
    output shift_clock, shift_data, irq_ack, unhold, nmi_in
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised video timing / scan-address generator with double-buffered scroll
// and vsync interrupt. Optional raster-line interrupt enabled by RASTER_IRQ_EN.
module video_timing_gen #(
  parameter int H_TOTAL      = 400,
  parameter int H_VISIBLE    = 320,
  parameter int H_SYNC_START = 328,
  parameter int H_SYNC_END   = 376,
  parameter int V_TOTAL      = 525,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int LINE_SHIFT   = 1,
  parameter int PIX_W        = 9,
  parameter int ROW_W        = 8
) (
  input  logic                master_clock,
  input  logic                reset,
  video_timing_gen_if.master  vid
`ifdef RASTER_IRQ_EN
  ,
  input  logic [9:0]          raster_line,
  output logic                raster_irq_n
`endif
);

  localparam logic [PIX_W-1:0] H_LAST = PIX_W'(H_TOTAL - 1);
  localparam logic [PIX_W-1:0] H_VIS  = PIX_W'(H_VISIBLE);
  localparam logic [PIX_W-1:0] H_SS   = PIX_W'(H_SYNC_START);
  localparam logic [PIX_W-1:0] H_SE   = PIX_W'(H_SYNC_END);
  localparam logic [9:0]       V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]       V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0]       V_SS   = 10'(V_SYNC_START);
  localparam logic [9:0]       V_SE   = 10'(V_SYNC_END);

  logic             half_q;
  logic [PIX_W-1:0] pixel_q;
  logic [9:0]       line_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             irq_q;
  logic             hold_q;
  logic [ROW_W-1:0] shadow_q;
  logic [ROW_W-1:0] active_q;
  logic [2:0]       sc_sync_q;

  logic             tick;
  logic             line_adv;
  logic             frame_wrap;
  logic             shift_edge;
  logic             irq_set;
  logic             irq_clr;
  logic [PIX_W-1:0] pixel_next;
  logic [9:0]       line_next;
  logic [9:0]       line_sh;
  logic [ROW_W-1:0] row_addr;

  always_comb begin
    tick       = ~half_q;
    pixel_next = (pixel_q == H_LAST) ? '0 : pixel_q + 1'b1;
    line_next  = (line_q == V_LAST) ? '0 : line_q + 10'd1;
    line_adv   = tick && (pixel_q == H_LAST);
    frame_wrap = line_adv && (line_q == V_LAST);
    shift_edge = sc_sync_q[1] & ~sc_sync_q[2];
    irq_set    = line_adv && (line_next == V_SS) && !hold_q && vid.nmi_in;
    irq_clr    = vid.irq_ack || (line_adv && (line_next == V_SE));
    line_sh    = line_q >> LINE_SHIFT;
    row_addr   = line_sh[ROW_W-1:0] + active_q;
  end

  always_ff @(posedge master_clock) begin
    if (!reset) begin
      half_q    <= 1'b0;
      pixel_q   <= '0;
      line_q    <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      irq_q     <= 1'b1;
      hold_q    <= 1'b1;
      shadow_q  <= '0;
      active_q  <= '0;
      sc_sync_q <= '0;
    end else begin
      half_q    <= ~half_q;
      sc_sync_q <= {sc_sync_q[1:0], vid.shift_clock};
      // Syncs are decided from the next counter value so they line up with blanking.
      if (tick) begin
        pixel_q <= pixel_next;
        if (pixel_next == H_SS)      hsync_q <= 1'b0;
        else if (pixel_next == H_SE) hsync_q <= 1'b1;
      end
      if (line_adv) begin
        line_q <= line_next;
        if (line_next == V_SS)      vsync_q <= 1'b0;
        else if (line_next == V_SE) vsync_q <= 1'b1;
      end
      if (frame_wrap) active_q <= shadow_q;
      // Scroll bits only land in blanking so a frame never scrolls mid-scan.
      if (shift_edge && (line_q >= V_VIS))
        shadow_q <= {shadow_q[ROW_W-2:0], vid.shift_data};
      if (irq_clr)      irq_q <= 1'b1;
      else if (irq_set) irq_q <= 1'b0;
      if (vid.unhold) hold_q <= 1'b0;
    end
  end

`ifdef RASTER_IRQ_EN
  logic [9:0] raster_q;
  logic       raster_irq_q;

  always_ff @(posedge master_clock) begin
    if (!reset) begin
      raster_q     <= '0;
      raster_irq_q <= 1'b1;
    end else begin
      if (vid.irq_ack)   raster_irq_q <= 1'b1;
      else if (line_adv) raster_irq_q <= !((line_next == raster_q) && !hold_q);
      if (frame_wrap)    raster_q <= raster_line;
    end
  end

  assign raster_irq_n = raster_irq_q;
`endif

  assign vid.phi2      = half_q;
  assign vid.not_phi2  = ~half_q;
  assign vid.hsync     = hsync_q;
  assign vid.vsync     = vsync_q;
  assign vid.visible   = (pixel_q < H_VIS) && (line_q < V_VIS);
  assign vid.scan_addr = {row_addr, pixel_q};
  assign vid.line_y    = line_q;
  assign vid.irq_n     = irq_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a shrunken geometry (20x20 ticks) so several
// frames fit in a short run; a tick-count model fills the expected queue.
module tb_video_timing_gen;

  localparam int HT = 20, HV = 12, HSS = 14, HSE = 17;
  localparam int VT = 20, VV = 12, VSS = 14, VSE = 16;
  localparam int LS = 1, PW = 5, RW = 8;

  typedef struct packed {
    logic          phi2;
    logic          not_phi2;
    logic          hsync;
    logic          vsync;
    logic          visible;
    logic [PW+RW-1:0] addr;
    logic [9:0]    line;
    logic          irq;
    logic          rirq;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic master_clock = 1'b0;
  logic reset = 1'b0;
  logic [EXP_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_miss = 0;

  video_timing_gen_if #(.PIX_W(PW), .ROW_W(RW)) vif ();

`ifdef RASTER_IRQ_EN
  logic [9:0] raster_line = 10'd5;
  logic       raster_irq_n;
`endif

  video_timing_gen #(
    .H_TOTAL(HT), .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .V_TOTAL(VT), .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
    .LINE_SHIFT(LS), .PIX_W(PW), .ROW_W(RW)
  ) dut (
    .master_clock(master_clock),
    .reset(reset),
    .vid(vif)
`ifdef RASTER_IRQ_EN
    ,
    .raster_line(raster_line),
    .raster_irq_n(raster_irq_n)
`endif
  );

  // clock / reset
  always #5 master_clock = ~master_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: position derived from ticks elapsed since reset
  int         m_cyc = 0, m_ticks = 0, m_pix = 0, m_line = 0;
  logic       m_irq = 1'b1, m_hold = 1'b1, m_rirq = 1'b1;
  logic [7:0] m_active = '0;
  logic [9:0] m_rlat = '0;
  logic [7:0] tb_shadow = '0;

  always @(posedge master_clock) begin
    logic adv, wrap, old_half;
    logic [9:0] rl;
    exp_t e;
    if (!reset) begin
      m_cyc = 0; m_ticks = 0; m_irq = 1'b1; m_hold = 1'b1;
      m_active = '0; m_rlat = '0; m_rirq = 1'b1;
    end else begin
      old_half = m_cyc[0];
      m_cyc++;
      adv = 1'b0;
      if (!old_half) begin
        m_ticks++;
        adv = (m_ticks % HT) == 0;
      end
      wrap = adv && (((m_ticks / HT) % VT) == 0);
      if (vif.irq_ack)                                  m_irq = 1'b1;
      else if (adv && ((m_ticks / HT) % VT) == VSE)     m_irq = 1'b1;
      else if (adv && ((m_ticks / HT) % VT) == VSS && !m_hold && vif.nmi_in) m_irq = 1'b0;
      if (vif.irq_ack) m_rirq = 1'b1;
      else if (adv)    m_rirq = !((((m_ticks / HT) % VT) == int'(m_rlat)) && !m_hold);
`ifdef RASTER_IRQ_EN
      rl = raster_line;
`else
      rl = 10'd5;
`endif
      if (wrap) begin
        m_rlat   = rl;
        m_active = tb_shadow;
      end
      if (vif.unhold) m_hold = 1'b0;
    end
    m_pix  = m_ticks % HT;
    m_line = (m_ticks / HT) % VT;
    e.phi2     = m_cyc[0];
    e.not_phi2 = ~m_cyc[0];
    e.hsync    = !(m_pix >= HSS && m_pix < HSE);
    e.vsync    = !(m_line >= VSS && m_line < VSE);
    e.visible  = (m_pix < HV) && (m_line < VV);
    e.addr     = {8'(((m_line >> LS) + int'(m_active)) % 256), 5'(m_pix)};
    e.line     = 10'(m_line);
    e.irq      = m_irq;
    e.rirq     = m_rirq;
    exp_q.push_back(e);
  end

  // scoreboard: compare away from the active edge
  always @(negedge master_clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("phi2",    {30'd0, vif.phi2, vif.not_phi2}, {30'd0, e.phi2, e.not_phi2});
      check("syncs",   {30'd0, vif.hsync, vif.vsync},   {30'd0, e.hsync, e.vsync});
      check("visible", {31'd0, vif.visible},            {31'd0, e.visible});
      check("scan_addr", 32'(vif.scan_addr),           32'(e.addr));
      check("line_y",  32'(vif.line_y),                 32'(e.line));
      check("irq_n",   {31'd0, vif.irq_n},              {31'd0, e.irq});
`ifdef RASTER_IRQ_EN
      check("raster_irq_n", {31'd0, raster_irq_n},      {31'd0, e.rirq});
`endif
    end
  end

  // driver tasks
  task automatic wait_pos(input int line, input int pix);
    bit hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge master_clock); #2;
      hit = (m_line == line) && (m_pix == pix);
    end
    if (!hit) check("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_ack();
    @(posedge master_clock); #2 vif.irq_ack = 1'b1;
    @(posedge master_clock); #2 vif.irq_ack = 1'b0;
  endtask

  task automatic pulse_unhold();
    @(posedge master_clock); #2 vif.unhold = 1'b1;
    @(posedge master_clock); #2 vif.unhold = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] b, input bit counted);
    for (int i = 7; i >= 0; i--) begin
      vif.shift_data  = b[i];
      vif.shift_clock = 1'b0;
      repeat (4) @(posedge master_clock);
      #2 vif.shift_clock = 1'b1;
      if (counted) tb_shadow = {tb_shadow[6:0], b[i]};
      repeat (4) @(posedge master_clock);
      #2;
    end
    vif.shift_clock = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge master_clock); #2 reset = 1'b0;
    tb_shadow = '0;
    @(posedge master_clock); #2 reset = 1'b1;
  endtask

  initial begin
    vif.shift_clock = 1'b0;
    vif.shift_data  = 1'b0;
    vif.irq_ack     = 1'b0;
    vif.unhold      = 1'b0;
    vif.nmi_in      = 1'b1;
    repeat (3) @(posedge master_clock);
    #2 reset = 1'b1;

    // frame 0: hold set, visible-line shift ignored, blanking shift of 0x10
    wait_pos(2, 0);
    shift_byte(8'hFF, 1'b0);
    wait_pos(12, 0);
    shift_byte(8'h10, 1'b1);

    // frame 1: row offset 0x10 live, interrupts released, load 0xF8 for wrap case
    wait_pos(1, 0);
    pulse_unhold();
    wait_pos(12, 0);
    shift_byte(8'hF8, 1'b1);

    // frame 2: another master owns /NMI across the vsync line
    wait_pos(12, 0);
    vif.nmi_in = 1'b0;
    wait_pos(15, 0);
    vif.nmi_in = 1'b1;

    // frame 3: early acknowledge
    wait_pos(15, 0);
    pulse_ack();

    // frame 4: pending scroll then reset mid-frame discards it
    wait_pos(12, 0);
    shift_byte(8'h5A, 1'b1);
    wait_pos(15, 5);
    do_reset();
    wait_pos(19, 0);
    wait_pos(3, 0);

    repeat (2) @(negedge master_clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
